// File: rtl/divu_hilo_pkg.sv
// Shared funct codes and divider state encoding, common with ALU control.
package divu_hilo_pkg;
    localparam logic [5:0] FUNCT_DIVU    = 6'd27;
    localparam logic [5:0] FUNCT_MFHI    = 6'd16;
    localparam logic [5:0] FUNCT_MFLO    = 6'd18;
    localparam logic [5:0] FUNCT_HILO_WR = 6'd63;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divState_t;
endpackage

// File: rtl/hilo_reg.sv
// Architectural Hi/Lo register pair; both halves load together on a commit.
module hilo_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] hiIn,
    input  logic [31:0] loIn,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (we) begin
            hi <= hiIn;
            lo <= loIn;
        end
    end
endmodule

// File: rtl/divu_hilo.sv
// Unsigned 32-bit restoring divider, one quotient bit per cycle, committing
// its result into Hi/Lo on command and serving MFHI/MFLO reads.
module divu_hilo
    import divu_hilo_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Signal,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic [31:0] dataOut,
    output logic        busy,
    output logic        done
);
    divState_t   state, nextState;
    logic [5:0]  prevSignal;
    logic [31:0] rem, quot, divisor;
    logic [4:0]  count;
    logic        start, commit;
    logic [32:0] partial;
    logic [31:0] diff, remNext;
    logic        stepOk;
    logic [31:0] hi, lo;

    // Start is edge-triggered on the command so a held DIVU cannot re-launch.
    assign start  = (Signal == FUNCT_DIVU) && (prevSignal != FUNCT_DIVU) &&
                    (state == IDLE || state == DONE);
    assign commit = (state == DONE) && (Signal == FUNCT_HILO_WR);

    // Any in-range remainder fits in 32 bits, so the low word of the
    // difference is exact whenever the subtraction is taken.
    assign partial = {rem, quot[31]};
    assign stepOk  = partial >= {1'b0, divisor};
    assign diff    = partial[31:0] - divisor;
    assign remNext = stepOk ? diff : partial[31:0];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (start) nextState = RUN;
            RUN:  if (count == 5'd31) nextState = DONE;
            DONE: begin
                if (start)       nextState = RUN;
                else if (commit) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prevSignal <= '0;
            rem        <= '0;
            quot       <= '0;
            divisor    <= '0;
            count      <= '0;
            dataOut    <= '0;
        end else begin
            prevSignal <= Signal;
            if (start) begin
                quot    <= dataA;
                divisor <= dataB;
                rem     <= '0;
                count   <= '0;
            end else if (state == RUN) begin
                rem   <= remNext;
                quot  <= {quot[30:0], stepOk};
                count <= count + 5'd1;
            end
            if (Signal == FUNCT_MFHI)      dataOut <= hi;
            else if (Signal == FUNCT_MFLO) dataOut <= lo;
        end
    end

    hilo_reg uHilo (
        .clk   (clk),
        .reset (reset),
        .we    (commit),
        .hiIn  (rem),
        .loIn  (quot),
        .hi    (hi),
        .lo    (lo)
    );
endmodule
